// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory access sequencer and IR decode.
package mem_seq_pkg;

    localparam int unsigned IR_W  = 32;
    localparam int unsigned CNT_W = 4;

    // IR field bit positions
    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned JADDR_MSB = 25;
    localparam int unsigned JADDR_LSB = 0;

    // Opcodes
    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_LUI = 6'h0f;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;

    // R-type function codes
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_BREAK = 6'h0d;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        CAPTURE = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } mem_seq_state_e;

    // Word alignment test on the two low address bits
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_sequencer_ir_fields.sv
// Combinational slicer of the instruction register into its decode fields.
module ir_fields
    import mem_seq_pkg::*;
(
    input  logic [IR_W-1:0] ir_i,
    output logic [5:0]      op_o,
    output logic [4:0]      rs_o,
    output logic [4:0]      rt_o,
    output logic [4:0]      rd_o,
    output logic [5:0]      funct_o,
    output logic [15:0]     imm16_o,
    output logic [25:0]     jaddr_o
);

    assign op_o    = ir_i[OP_MSB:OP_LSB];
    assign rs_o    = ir_i[RS_MSB:RS_LSB];
    assign rt_o    = ir_i[RT_MSB:RT_LSB];
    assign rd_o    = ir_i[RD_MSB:RD_LSB];
    assign funct_o = ir_i[FUNCT_MSB:FUNCT_LSB];
    assign imm16_o = ir_i[IMM_MSB:IMM_LSB];
    assign jaddr_o = ir_i[JADDR_MSB:JADDR_LSB];

endmodule

// File: rtl/mem_sequencer.sv
// Memory access sequencer: accepts one read/write request, holds the address,
// waits out the fixed read latency and captures data into IR or MDR.
// Optional word-alignment check enabled by defining MEM_SEQ_ALIGN_CHECK_EN.
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              wr,
    input  logic              IorD,
    input  logic              to_mdr,
    input  logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] AluOut,
    input  logic [DATA_W-1:0] WData,
    input  logic [DATA_W-1:0] MemRData,
    output logic [DATA_W-1:0] MemAddr,
    output logic              MemWr,
    output logic [DATA_W-1:0] MemWData,
    output logic              ready,
    output logic              done,
    output logic [IR_W-1:0]   IR,
    output logic [DATA_W-1:0] MDR,
    output logic [5:0]        OP,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        Funct,
    output logic [15:0]       Imm16,
    output logic [25:0]       JAddr
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    ,
    output logic              align_err
`endif
);

    mem_seq_state_e    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] addr_q, wdata_q, mdr_q;
    logic [IR_W-1:0]   ir_q;
    logic              to_mdr_q;
    logic              memwr_q, memwr_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              accept_c, capture_c, misalign_c;
    logic [DATA_W-1:0] addr_sel_c;

    assign addr_sel_c = IorD ? AluOut : PC;

`ifdef MEM_SEQ_ALIGN_CHECK_EN
    assign misalign_c = addr_misaligned(addr_sel_c[1:0]);
`else
    assign misalign_c = 1'b0;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (misalign_c)  state_d = DONE;
                    else if (wr)     state_d = WR;
                    else             state_d = RD_WAIT;
                end
            end
            RD_WAIT: if (cnt_q == '0) state_d = CAPTURE;
            CAPTURE: state_d = DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of registered outputs and the latency counter
    always_comb begin
        accept_c  = (state_q == IDLE) && req;
        capture_c = (state_q == CAPTURE);
        ready_d   = (state_d == IDLE);
        done_d    = (state_d == DONE);
        memwr_d   = (state_d == WR);
        cnt_d     = cnt_q;
        if (accept_c) begin
            cnt_d = CNT_W'(RD_LATENCY - 1);
        end else if ((state_q == RD_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Address/data latch, capture registers and handshake outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            to_mdr_q <= 1'b0;
            ir_q     <= '0;
            mdr_q    <= '0;
            cnt_q    <= '0;
            memwr_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            memwr_q <= memwr_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            if (accept_c) begin
                addr_q   <= addr_sel_c;
                wdata_q  <= WData;
                to_mdr_q <= to_mdr;
            end
            if (capture_c) begin
                if (to_mdr_q) mdr_q <= MemRData;
                else          ir_q  <= IR_W'(MemRData);
            end
        end
    end

`ifdef MEM_SEQ_ALIGN_CHECK_EN
    logic align_err_q;

    // Alignment error flag, refreshed at every acceptance
    always_ff @(posedge Clk) begin
        if (Reset) begin
            align_err_q <= 1'b0;
        end else if (accept_c) begin
            align_err_q <= misalign_c;
        end
    end

    assign align_err = align_err_q;
`endif

    assign MemAddr  = addr_q;
    assign MemWData = wdata_q;
    assign MemWr    = memwr_q;
    assign done     = done_q;
    assign ready    = ready_q;
    assign IR       = ir_q;
    assign MDR      = mdr_q;

    ir_fields u_ir_fields (
        .ir_i    (ir_q),
        .op_o    (OP),
        .rs_o    (rs),
        .rt_o    (rt),
        .rd_o    (rd),
        .funct_o (Funct),
        .imm16_o (Imm16),
        .jaddr_o (JAddr)
    );

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboard bench for mem_sequencer: a latency-honest memory model, a
// transaction-level reference model and a per-cycle monitor.
// Define MEM_SEQ_ALIGN_CHECK_EN to exercise the alignment-check build.
module tb_mem_sequencer;

    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DW     = 32;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset, req, wr, IorD, to_mdr;
    logic [DW-1:0] PC, AluOut, WData, MemRData;
    logic [DW-1:0] MemAddr, MemWData, MDR;
    logic          MemWr, ready, done;
    logic [31:0]   IR;
    logic [5:0]    OP, Funct;
    logic [4:0]    rs, rt, rd;
    logic [15:0]   Imm16;
    logic [25:0]   JAddr;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    logic          align_err;
`endif

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;

    mem_sequencer #(.RD_LATENCY(RD_LAT), .DATA_W(DW)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .wr(wr), .IorD(IorD), .to_mdr(to_mdr),
        .PC(PC), .AluOut(AluOut), .WData(WData), .MemRData(MemRData),
        .MemAddr(MemAddr), .MemWr(MemWr), .MemWData(MemWData),
        .ready(ready), .done(done), .IR(IR), .MDR(MDR),
        .OP(OP), .rs(rs), .rt(rt), .rd(rd), .Funct(Funct), .Imm16(Imm16), .JAddr(JAddr)
`ifdef MEM_SEQ_ALIGN_CHECK_EN
        , .align_err(align_err)
`endif
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Initial memory contents: a fixed hash of the byte address
    function automatic logic [31:0] init_word(input logic [9:0] a);
        return ({22'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- memory model: data valid only after RD_LAT stable cycles
    logic [31:0] wmem [0:1023];
    bit          wvld [0:1023];
    bit [31:0]   prev_addr;
    int unsigned stable = 0;

    always @(posedge Clk) begin
        prev_addr <= MemAddr;
        if (MemAddr != prev_addr) stable <= 1;
        else if (stable < 100)    stable <= stable + 1;
        if (MemWr) begin
            wmem[MemAddr[9:0]] <= MemWData;
            wvld[MemAddr[9:0]] <= 1'b1;
        end
    end

    always_comb begin
        if (stable >= RD_LAT)
            MemRData = wvld[MemAddr[9:0]] ? wmem[MemAddr[9:0]] : init_word(MemAddr[9:0]);
        else
            MemRData = 32'hBAD0_0000 | stable;
    end

    // ---------------- reference model and scoreboard
    typedef struct {
        bit          is_wr;
        bit          mis;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ir;
        logic [31:0] mdr;
        int unsigned acc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ref_mem [0:1023];
    bit          ref_vld [0:1023];
    logic [31:0] ref_ir = '0;
    logic [31:0] ref_mdr = '0;

    function automatic logic [31:0] ref_rd(input logic [9:0] a);
        return ref_vld[a] ? ref_mem[a] : init_word(a);
    endfunction

    // Cycles from acceptance to the done pulse
    function automatic int unsigned lat_of(input exp_t e);
        if (e.mis)   return 0;
        if (e.is_wr) return 1;
        return RD_LAT + 1;
    endfunction

    // ---------------- monitor
    exp_t h;
    bit   have, exp_mw, exp_dn;

    always @(negedge Clk) begin
        if (!Reset) begin
            have   = (sbq.size() != 0);
            exp_mw = 1'b0;
            exp_dn = 1'b0;
            if (have) begin
                h      = sbq[0];
                exp_mw = h.is_wr && !h.mis && (cyc == h.acc);
                exp_dn = (cyc == h.acc + lat_of(h));
            end
            chk("MemWr", MemWr, exp_mw);
            if (exp_mw) begin
                chk("store_addr", MemAddr, h.addr);
                chk("store_data", MemWData, h.wdata);
            end
            chk("done", done, exp_dn);
            if (have && cyc >= h.acc && cyc <= h.acc + lat_of(h)) begin
                chk("ready_busy", ready, 1'b0);
                if (!h.mis) chk("addr_hold", MemAddr, h.addr);
            end
            if (have && cyc >= h.acc + lat_of(h)) begin
                chk("IR", IR, h.ir);
                chk("MDR", MDR, h.mdr);
                chk("OP", OP, h.ir >> 26);
                chk("rs", rs, (h.ir >> 21) & 32'h1F);
                chk("rt", rt, (h.ir >> 16) & 32'h1F);
                chk("rd", rd, (h.ir >> 11) & 32'h1F);
                chk("Funct", Funct, h.ir & 32'h3F);
                chk("Imm16", Imm16, h.ir & 32'hFFFF);
                chk("JAddr", JAddr, h.ir & 32'h03FF_FFFF);
`ifdef MEM_SEQ_ALIGN_CHECK_EN
                chk("align_err", align_err, h.mis);
`endif
                void'(sbq.pop_front());
            end
        end
    end

    // ---------------- driver
    task automatic wait_ready();
        int n = 0;
        @(negedge Clk);
        while (!ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (!ready) chk("ready_timeout", ready, 1'b1);
    endtask

    task automatic scramble();
        PC     = $urandom_range(0, 1023);
        AluOut = $urandom_range(0, 1023);
        WData  = $urandom;
        wr     = 1'($urandom);
        IorD   = 1'($urandom);
        to_mdr = 1'($urandom);
    endtask

    task automatic issue(input bit w, input bit sel, input bit tm, input logic [31:0] pc_v,
                         input logic [31:0] alu_v, input logic [31:0] wd, input bit hold);
        exp_t e;
        int   n;
        wait_ready();
        req = 1'b1; wr = w; IorD = sel; to_mdr = tm; PC = pc_v; AluOut = alu_v; WData = wd;
        e.is_wr = w;
        e.addr  = sel ? alu_v : pc_v;
        e.wdata = wd;
        e.acc   = cyc + 1;
        e.mis   = ALIGN_EN && (e.addr[1:0] != 2'b00);
        if (!e.mis) begin
            if (w) begin
                ref_mem[e.addr[9:0]] = wd;
                ref_vld[e.addr[9:0]] = 1'b1;
            end else if (tm) begin
                ref_mdr = ref_rd(e.addr[9:0]);
            end else begin
                ref_ir = ref_rd(e.addr[9:0]);
            end
        end
        e.ir  = ref_ir;
        e.mdr = ref_mdr;
        sbq.push_back(e);
        @(negedge Clk);
        n = 0;
        while (hold && !done && n < 40) begin
            scramble();
            @(negedge Clk);
            n++;
        end
        req = 1'b0;
        scramble();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; req = 1'b0; wr = 1'b0; IorD = 1'b0; to_mdr = 1'b0;
        PC = '0; AluOut = '0; WData = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_MemWr", MemWr, 1'b0);
        chk("rst_IR", IR, 32'h0);
        chk("rst_MDR", MDR, 32'h0);
        chk("rst_MemAddr", MemAddr, 32'h0);
        chk("rst_MemWData", MemWData, 32'h0);

        // Preload memory through the sequencer, then fetch and load
        issue(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0004, 32'h8C22_0010, 1'b0);
        issue(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'h0, 1'b0);
        wait_ready();
        chk("fetch_IR", IR, 32'h8C22_0010);
        chk("fetch_OP", OP, 6'h23);
        chk("fetch_rs", rs, 5'd1);
        chk("fetch_rt", rt, 5'd2);
        chk("fetch_Imm16", Imm16, 16'h0010);
        chk("fetch_MDR_kept", MDR, 32'h0);
        issue(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0100, 32'h0, 1'b0);
        wait_ready();
        chk("load_MemAddr", MemAddr, 32'h0000_0100);
        chk("load_MDR", MDR, 32'hDEAD_BEEF);
        chk("load_IR_kept", IR, 32'h8C22_0010);
        issue(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0020, 32'h1234_5678, 1'b0);

        // req held high with PC changing mid-access
        issue(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1'b1);
        repeat (6) @(negedge Clk);

        // Reset during RD_WAIT
        wait_ready();
        req = 1'b1; wr = 1'b0; IorD = 1'b0; to_mdr = 1'b0; PC = 32'h0000_0004;
        @(negedge Clk);
        req = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        ref_ir = '0;
        ref_mdr = '0;
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_IR", IR, 32'h0);
        chk("midrst_MDR", MDR, 32'h0);
        chk("midrst_done", done, 1'b0);
        repeat (6) @(negedge Clk);

`ifdef MEM_SEQ_ALIGN_CHECK_EN
        issue(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0102, 32'hCAFE_F00D, 1'b0);
`endif

        for (int i = 0; i < 150; i++) begin
            issue(($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom,
                  1'($urandom));
        end
        wait_ready();
        repeat (4) @(negedge Clk);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
